// File: rtl/bcd_adder.sv
// bcd_adder: packed-BCD adder with registered outputs.
//
// Adds two DIGITS-digit packed BCD operands plus a decimal carry-in, rippling
// the decimal carry from digit 0 upward. Any operand digit above 9 flags error
// and forces sum and carry to zero for that result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every stage
//   in_valid   one-cycle strobe; a, b, cin are sampled on that edge
//   a, b       addends, packed BCD, digit 0 in bits [3:0]
//   cin        decimal carry-in
//   sum        registered BCD sum
//   carry      registered carry-out of the top digit
//   error      registered invalid-digit flag
//   out_valid  one-cycle strobe marking a new sum/carry/error
//
// Build option: define BCD_ADDER_PIPE_EN to add a second register stage
// (latency two clocks instead of one, throughput unchanged).

module bcd_adder #(
   parameter int unsigned DIGITS = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  carry,
   output logic                  error,
   output logic                  out_valid
);

   localparam int unsigned W = 4 * DIGITS;

   logic [W-1:0] add_sum;
   logic         add_carry;
   logic         add_error;
   logic [4:0]   dig_t;
   logic         dig_c;

   // Ripple decimal adder with per-digit +6 correction.
   always_comb begin
      add_sum   = '0;
      add_error = 1'b0;
      dig_t     = '0;
      dig_c     = cin;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (a[4*d +: 4] > 4'd9 || b[4*d +: 4] > 4'd9) begin
            add_error = 1'b1;
         end
         dig_t = {1'b0, a[4*d +: 4]} + {1'b0, b[4*d +: 4]} + {4'b0000, dig_c};
         if (dig_t > 5'd9) begin
            add_sum[4*d +: 4] = dig_t[3:0] + 4'd6;
            dig_c             = 1'b1;
         end else begin
            add_sum[4*d +: 4] = dig_t[3:0];
            dig_c             = 1'b0;
         end
      end
      add_carry = dig_c;
      // An invalid digit voids the whole result.
      if (add_error) begin
         add_sum   = '0;
         add_carry = 1'b0;
      end
   end

   // Stage 1: result registers; hold their value when no operation is sampled.
   logic [W-1:0] s1_sum_d, s1_sum_q;
   logic         s1_carry_d, s1_carry_q;
   logic         s1_error_d, s1_error_q;
   logic         s1_valid_d, s1_valid_q;

   always_comb begin
      s1_valid_d = in_valid;
      s1_sum_d   = s1_sum_q;
      s1_carry_d = s1_carry_q;
      s1_error_d = s1_error_q;
      if (in_valid) begin
         s1_sum_d   = add_sum;
         s1_carry_d = add_carry;
         s1_error_d = add_error;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sum_q   <= '0;
         s1_carry_q <= 1'b0;
         s1_error_q <= 1'b0;
         s1_valid_q <= 1'b0;
      end else begin
         s1_sum_q   <= s1_sum_d;
         s1_carry_q <= s1_carry_d;
         s1_error_q <= s1_error_d;
         s1_valid_q <= s1_valid_d;
      end
   end

`ifdef BCD_ADDER_PIPE_EN
   // Stage 2: copies stage 1 only when it holds a fresh result, so outputs
   // keep their last value between operations.
   logic [W-1:0] s2_sum_d, s2_sum_q;
   logic         s2_carry_d, s2_carry_q;
   logic         s2_error_d, s2_error_q;
   logic         s2_valid_d, s2_valid_q;

   always_comb begin
      s2_valid_d = s1_valid_q;
      s2_sum_d   = s2_sum_q;
      s2_carry_d = s2_carry_q;
      s2_error_d = s2_error_q;
      if (s1_valid_q) begin
         s2_sum_d   = s1_sum_q;
         s2_carry_d = s1_carry_q;
         s2_error_d = s1_error_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_sum_q   <= '0;
         s2_carry_q <= 1'b0;
         s2_error_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s2_sum_q   <= s2_sum_d;
         s2_carry_q <= s2_carry_d;
         s2_error_q <= s2_error_d;
         s2_valid_q <= s2_valid_d;
      end
   end

   assign sum       = s2_sum_q;
   assign carry     = s2_carry_q;
   assign error     = s2_error_q;
   assign out_valid = s2_valid_q;
`else
   assign sum       = s1_sum_q;
   assign carry     = s1_carry_q;
   assign error     = s1_error_q;
   assign out_valid = s1_valid_q;
`endif

endmodule

// File: tb/tb_bcd_adder.sv
// Self-checking bench for bcd_adder: one single-digit and one two-digit
// instance, scoreboard queues filled by the driver and drained by a monitor.

module tb_bcd_adder;

`ifdef BCD_ADDER_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [7:0] sum;
      logic       carry;
      logic       error;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iv1 = 1'b0, iv2 = 1'b0;
   logic [3:0] a1 = '0, b1 = '0;
   logic [7:0] a2 = '0, b2 = '0;
   logic       cin1 = 1'b0, cin2 = 1'b0;
   logic [3:0] sum1;
   logic [7:0] sum2;
   logic       carry1, carry2, err1, err2, ov1, ov2;

   exp_t       q [2][$];
   logic [7:0] last_sum [2];
   logic       last_carry [2];
   logic       last_err [2];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bcd_adder #(.DIGITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
      .sum(sum1), .carry(carry1), .error(err1), .out_valid(ov1)
   );

   bcd_adder #(.DIGITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .a(a2), .b(b2), .cin(cin2),
      .sum(sum2), .carry(carry2), .error(err2), .out_valid(ov2)
   );

   task automatic mon(input int id, input logic [7:0] s, input logic c, input logic e,
                      input logic v);
      exp_t x;
      n_cmp++;
      if (v) begin
         if (q[id].size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_out_valid dut%0d: got sum=%h carry=%b error=%b, want none",
                     id + 1, s, c, e);
         end else begin
            x = q[id].pop_front();
            if (s !== x.sum || c !== x.carry || e !== x.error || cyc !== x.cyc) begin
               n_bad++;
               $display("FAIL result dut%0d: got sum=%h carry=%b error=%b cyc=%0d, want sum=%h carry=%b error=%b cyc=%0d",
                        id + 1, s, c, e, cyc, x.sum, x.carry, x.error, x.cyc);
            end
            last_sum[id]   = x.sum;
            last_carry[id] = x.carry;
            last_err[id]   = x.error;
         end
      end else if (s !== last_sum[id] || c !== last_carry[id] || e !== last_err[id]) begin
         n_bad++;
         $display("FAIL hold dut%0d: got sum=%h carry=%b error=%b, want sum=%h carry=%b error=%b",
                  id + 1, s, c, e, last_sum[id], last_carry[id], last_err[id]);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            last_sum[i]   = '0;
            last_carry[i] = 1'b0;
            last_err[i]   = 1'b0;
         end
      end else begin
         mon(0, {4'h0, sum1}, carry1, err1, ov1);
         mon(1, sum2, carry2, err2, ov2);
      end
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // Called just after a rising edge; the op is sampled on the next edge.
   task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [3:0] es, input logic ec, input logic ee);
      exp_t x;
      a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
      x.sum = {4'h0, es}; x.carry = ec; x.error = ee; x.cyc = cyc + LAT;
      q[0].push_back(x);
      @(posedge clk); #1;
      iv1 = 1'b0;
   endtask

   task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input logic ee);
      exp_t x;
      a2 = a; b2 = b; cin2 = c; iv2 = 1'b1;
      x.sum = es; x.carry = ec; x.error = ee; x.cyc = cyc + LAT;
      q[1].push_back(x);
      @(posedge clk); #1;
      iv2 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int s;
      #2;
      check("reset_sum1", {4'h0, sum1}, 8'h00);
      check("reset_sum2", sum2, 8'h00);
      check("reset_flags", {4'h0, carry1, err1, carry2, err2}, 8'h00);
      check("reset_valid", {6'h0, ov1, ov2}, 8'h00);

      // Release between edges, first op accepted on the very next edge.
      #10;
      rst_n = 1'b1;
      op1(4'd4, 4'd3, 1'b1, 4'd8, 1'b0, 1'b0);
      op1(4'd9, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0);
      op1(4'd5, 4'd5, 1'b0, 4'd0, 1'b1, 1'b0);
      idle(2);
      op1(4'd13, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1);
      op1(4'd14, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1);
      op1(4'd7, 4'd11, 1'b0, 4'd0, 1'b0, 1'b1);
      op1(4'd0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0);
      idle(3);
      op2(8'h99, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      op2(8'h45, 8'h38, 1'b1, 8'h84, 1'b0, 1'b0);
      op2(8'h50, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0);
      op2(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
      op2(8'h3A, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1);
      op2(8'h99, 8'h99, 1'b1, 8'h99, 1'b1, 1'b0);
      idle(3);

      // All valid single-digit combinations, back-to-back.
      for (int a = 0; a < 10; a++) begin
         for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 2; c++) begin
               s = a + b + c;
               op1(4'(a), 4'(b), 1'(c), 4'(s % 10), 1'(s / 10), 1'b0);
            end
         end
      end
      idle(4);

      // Reset mid-stream with in_valid high: in-flight ops must vanish.
      op1(4'd2, 4'd2, 1'b0, 4'd4, 1'b0, 1'b0);
      a1 = 4'd6; b1 = 4'd7; cin1 = 1'b0; iv1 = 1'b1;
      a2 = 8'h21; b2 = 8'h43; cin2 = 1'b0; iv2 = 1'b1;
      #6;
      rst_n = 1'b0;
      #1;
      q[0].delete();
      q[1].delete();
      check("rst_sum1", {4'h0, sum1}, 8'h00);
      check("rst_sum2", sum2, 8'h00);
      check("rst_flags", {4'h0, carry1, err1, carry2, err2}, 8'h00);
      check("rst_valid", {6'h0, ov1, ov2}, 8'h00);
      @(posedge clk); #1;
      iv1 = 1'b0; iv2 = 1'b0;
      @(negedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      idle(4);
      op1(4'd8, 4'd1, 1'b0, 4'd9, 1'b0, 1'b0);
      op2(8'h19, 8'h19, 1'b1, 8'h39, 1'b0, 1'b0);

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 10 && (q[0].size() != 0 || q[1].size() != 0); i++) begin
         @(posedge clk); #1;
      end
      idle(2);
      n_cmp++;
      if (q[0].size() != 0 || q[1].size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d/%0d results outstanding, want 0/0",
                  q[0].size(), q[1].size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_adder.md
BCD_ADDER -- requirements
Module: bcd_adder

Interface
REQ-001 Parameter DIGITS, default 1: number of packed BCD digits per operand; legal range 1..8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  high for one cycle when a, b, cin carry an operation to be sampled.
REQ-005 a  input  4*DIGITS  addend; packed BCD, digit 0 in bits [3:0].
REQ-006 b  input  4*DIGITS  addend; same packing as a.
REQ-007 cin  input  1  decimal carry-in, value 0 or 1.
REQ-008 sum  output  4*DIGITS  registered BCD sum; same packing as a.
REQ-009 carry  output  1  registered decimal carry-out of the most significant digit.
REQ-010 error  output  1  registered flag; high when any input digit of a or b exceeds 9.
REQ-011 out_valid  output  1  registered; high for one cycle when sum, carry and error hold a new result.

Function
REQ-012 The block SHALL compute a + b + cin in decimal, digit by digit, with a ripple decimal carry from digit 0 upward.
REQ-013 Per digit, the block SHALL form the 5-bit binary sum t = a_d + b_d + c_in_d.
REQ-014 If t > 9, the block SHALL set sum_d = t + 6 (mod 16) and carry_out_d = 1.
REQ-015 If t <= 9, the block SHALL set sum_d = t and carry_out_d = 0.
REQ-016 The carry-out of the top digit SHALL drive carry.
REQ-017 Input validity: if any digit of a or b is in 10..15, error SHALL be 1, and sum and carry SHALL both be forced to 0 for that result.
REQ-018 cin SHALL never cause error.
REQ-019 Latency SHALL be one clock: the result of the operation sampled when in_valid = 1 on edge N appears on sum, carry and error with out_valid = 1 after edge N.
REQ-020 When in_valid = 0 at an edge, out_valid SHALL be 0 after that edge, and sum, carry and error SHALL hold their previous values.
REQ-021 Back-to-back: in_valid high on consecutive cycles SHALL yield one result per cycle, in order, with no bubbles.
REQ-022 There is no backpressure; every accepted operation SHALL produce exactly one out_valid pulse.

Reset
REQ-023 Asserting rst_n low SHALL immediately, without waiting for a clock edge, set sum = 0, carry = 0, error = 0 and out_valid = 0, including any pipeline registers.
REQ-024 An operation in flight when reset asserts SHALL be discarded, and no out_valid SHALL be produced for it.
REQ-025 Release of reset SHALL be synchronous to clk.
REQ-026 The first in_valid SHALL be accepted on the first rising edge at which rst_n is high.

Configuration
REQ-027 Macro BCD_ADDER_PIPE_EN, when defined, SHALL add a second register stage between the per-digit correction logic and the outputs, making latency two clocks for all outputs, including out_valid and error.
REQ-028 With BCD_ADDER_PIPE_EN defined, throughput SHALL remain one operation per cycle and reset SHALL clear both stages.
REQ-029 Without BCD_ADDER_PIPE_EN, latency SHALL be one clock as in REQ-019.
REQ-030 Results SHALL be identical with and without BCD_ADDER_PIPE_EN; only their timing differs.

Verification
REQ-031 DIGITS=1: a=4, b=3, cin=1 -> sum=8, carry=0, error=0, out_valid one cycle later.
REQ-032 DIGITS=1: a=9, b=9, cin=1 -> sum=9, carry=1; a=5, b=5, cin=0 -> sum=0, carry=1.
REQ-033 DIGITS=1 invalid inputs: a=13, b=15, cin=0, then a=14, b=4, cin=1, then a=7, b=11, cin=0 -> each gives error=1, sum=0, carry=0.
REQ-034 DIGITS=2: a=0x99, b=0x01, cin=0 -> sum=0x00, carry=1; a=0x45, b=0x38, cin=1 -> sum=0x84, carry=0.
REQ-035 Reset case: rst_n driven low mid-stream while in_valid is high -> all outputs are 0 at once, and no out_valid follows for the dropped operation.
REQ-036 Exhaustive: all 10x10x2 valid single-digit combinations, back-to-back, in both macro builds -> results match a decimal reference model at the stated latency.
